// File: rtl/peridot_csr_swi_mbox.sv
// PERIDOT host-bridge CSR slave: identification, key-locked CPU reset/LED control,
// a bank of software-interrupt channels and a host-to-CPU mailbox FIFO.
module peridot_csr_swi_mbox #(
   parameter int unsigned SWI_CHANNELS    = 4,
   parameter int unsigned MBOX_DEPTH      = 16,
   parameter int unsigned LED_WIDTH       = 4,
   parameter logic [31:0] CLASSID         = 32'h72A00000,
   parameter logic [31:0] TIMECODE        = 32'd1234567890,
   parameter logic [15:0] CPURESET_KEY    = 16'hdead,
   parameter int unsigned CPURESET_INIT   = 0,
   parameter              UIDREAD_FEATURE = "ENABLE"
) (
   input  logic                    csi_clk,
   input  logic                    rsi_reset_n,
   input  logic [3:0]              avs_address,
   input  logic                    avs_read,
   output logic [31:0]             avs_readdata,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   output logic                    ins_irq,
   output logic                    coe_cpureset,
   output logic [LED_WIDTH-1:0]    coe_led,
   output logic [SWI_CHANNELS-1:0] coe_swi,
   input  logic                    ru_bootsel,
   input  logic                    uid_enable,
   input  logic [63:0]             uid,
   input  logic                    uid_valid
);

   localparam int unsigned AW           = $clog2(MBOX_DEPTH);
   localparam int unsigned CW           = AW + 1;
   localparam logic [CW-1:0] DEPTH_C    = CW'(MBOX_DEPTH);
   localparam logic          UID_EN     = (UIDREAD_FEATURE == "ENABLE");
   localparam logic          CPURST_RST = CPURESET_INIT[0];

   logic [LED_WIDTH-1:0]    led_q, led_d;
   logic                    cpureset_q, cpureset_d;
   logic [31:0]             message_q, message_d;
   logic [SWI_CHANNELS-1:0] pending_q, pending_d;
   logic [SWI_CHANNELS-1:0] enable_q, enable_d;
   logic [AW-1:0]           wptr_q, wptr_d;
   logic [AW-1:0]           rptr_q, rptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic                    overflow_q, overflow_d;
   logic                    underflow_q, underflow_d;
   logic                    irqena_q, irqena_d;
   logic [31:0]             mem_q [MBOX_DEPTH];

   logic empty, full, mem_we;

   assign empty  = (count_q == '0);
   assign full   = (count_q == DEPTH_C);
   assign mem_we = avs_write && (avs_address == 4'd9) && !full;

   always_comb begin
      led_d       = led_q;
      cpureset_d  = cpureset_q;
      message_d   = message_q;
      pending_d   = pending_q;
      enable_d    = enable_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      irqena_d    = irqena_q;
      if (avs_write) begin
         case (avs_address)
            4'd4: begin
               led_d = avs_writedata[LED_WIDTH-1:0];
               if (CPURESET_KEY == 16'h0 || avs_writedata[31:16] == CPURESET_KEY) begin
                  cpureset_d = avs_writedata[8];
               end
            end
            4'd6: pending_d = pending_q | avs_writedata[SWI_CHANNELS-1:0];
            4'd7: pending_d = pending_q & ~avs_writedata[SWI_CHANNELS-1:0];
            4'd8: enable_d = avs_writedata[SWI_CHANNELS-1:0];
            4'd9: begin
               if (full) begin
                  overflow_d = 1'b1;
               end else begin
                  wptr_d  = wptr_q + AW'(1);
                  count_d = count_q + CW'(1);
               end
            end
            4'd10: begin
               irqena_d = avs_writedata[31];
               if (avs_writedata[17]) underflow_d = 1'b0;
               if (avs_writedata[16]) overflow_d = 1'b0;
               // Flush only rewinds the pointers; stored words stay in the array.
               if (avs_writedata[30]) begin
                  wptr_d  = '0;
                  rptr_d  = '0;
                  count_d = '0;
               end
            end
            4'd11: message_d = avs_writedata;
            default: ;
         endcase
      end else if (avs_read && avs_address == 4'd9) begin
         if (empty) begin
            underflow_d = 1'b1;
         end else begin
            rptr_d  = rptr_q + AW'(1);
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
      if (!rsi_reset_n) begin
         led_q       <= '0;
         cpureset_q  <= CPURST_RST;
         message_q   <= '0;
         pending_q   <= '0;
         enable_q    <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         irqena_q    <= 1'b0;
      end else begin
         led_q       <= led_d;
         cpureset_q  <= cpureset_d;
         message_q   <= message_d;
         pending_q   <= pending_d;
         enable_q    <= enable_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         irqena_q    <= irqena_d;
      end
   end

   always_ff @(posedge csi_clk) begin
      if (mem_we) begin
         mem_q[wptr_q] <= avs_writedata;
      end
   end

   always_comb begin
      avs_readdata = '0;
      case (avs_address)
         4'd0: avs_readdata = CLASSID;
         4'd1: avs_readdata = TIMECODE;
         4'd2: avs_readdata = UID_EN ? uid[31:0] : 32'h0;
         4'd3: avs_readdata = UID_EN ? uid[63:32] : 32'h0;
         4'd4: begin
            avs_readdata[LED_WIDTH-1:0] = led_q;
            avs_readdata[8]  = cpureset_q;
            avs_readdata[11] = ru_bootsel;
            avs_readdata[12] = 1'b1;
            avs_readdata[14] = uid_enable & UID_EN;
            avs_readdata[15] = uid_valid & UID_EN;
         end
         4'd5, 4'd6, 4'd7: avs_readdata[SWI_CHANNELS-1:0] = pending_q;
         4'd8: avs_readdata[SWI_CHANNELS-1:0] = enable_q;
         4'd9: if (!empty) avs_readdata = mem_q[rptr_q];
         4'd10: begin
            avs_readdata[31]     = irqena_q;
            avs_readdata[17]     = underflow_q;
            avs_readdata[16]     = overflow_q;
            avs_readdata[15]     = full;
            avs_readdata[14]     = empty;
            avs_readdata[CW-1:0] = count_q;
         end
         4'd11: avs_readdata = message_q;
         default: ;
      endcase
   end

   assign coe_led      = led_q;
   assign coe_cpureset = cpureset_q;
   assign coe_swi      = pending_q & enable_q;
   assign ins_irq      = (|(pending_q & enable_q)) | (irqena_q & ~empty);

endmodule
